toggle_pulse_syn: RTL and testbench

- Destination-side CDC synchronizer: samples an asynchronous (foreign-domain) level/toggle bus into the local clock domain through a multi-flop synchronizer chain.
- Outputs the synchronized level plus single-cycle rise/fall/toggle pulses per bit.
- Sits at the receive boundary of every toggle-based pulse crossing; the source domain converts its pulse to a level toggle and drives async_in.

---
 rtl/toggle_pulse_syn.sv | 68 ++++++
 tb/tb_toggle_pulse_syn.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_syn.sv
// Destination-side CDC synchronizer with per-bit rise/fall/toggle pulse detection.
// Optional edge counter output enabled by defining PULSE_SYN_EDGE_CNT_EN.
module toggle_pulse_syn #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] toggle_pulse,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef PULSE_SYN_EDGE_CNT_EN
    ,
    output logic [15:0]      edge_cnt
`endif
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
            $error("toggle_pulse_syn: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_r;
    logic [WIDTH-1:0] hist_r;

    // Synchronizer chain: plain flop-to-flop shift, no logic between stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_r <= {(SYNC_STAGES*WIDTH){RESET_VAL}};
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = stage_r[SYNC_STAGES-1];

    // History of the synchronized level, one cycle behind sync_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= {WIDTH{RESET_VAL}};
        end else begin
            hist_r <= sync_out;
        end
    end

    // Edge pulses come only from flop outputs, so they cannot glitch
    assign toggle_pulse = sync_out ^ hist_r;
    assign rise_pulse   = sync_out & ~hist_r;
    assign fall_pulse   = ~sync_out & hist_r;

`ifdef PULSE_SYN_EDGE_CNT_EN
    // Counts cycles in which any bit toggled; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= 16'h0000;
        end else if (|toggle_pulse) begin
            edge_cnt <= edge_cnt + 16'h0001;
        end else begin
            edge_cnt <= edge_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_toggle_pulse_syn.sv
// Scoreboard bench for toggle_pulse_syn: a 4-bit/2-stage instance and a 1-bit/3-stage instance.
module tb_toggle_pulse_syn;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] async_in = 4'b0001;
    logic [3:0] sync_out, toggle_pulse, rise_pulse, fall_pulse;
    logic [0:0] s3_sync, s3_tog, s3_rise, s3_fall;
`ifdef PULSE_SYN_EDGE_CNT_EN
    logic [15:0] edge_cnt, edge_cnt3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] tog;
        logic       s3;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [3:0] p1 = 4'h0;
    logic [3:0] p2 = 4'h0;

    always #5 clk = ~clk;

    toggle_pulse_syn #(.WIDTH(4), .SYNC_STAGES(2), .RESET_VAL(1'b0)) dut (
        .clk(clk), .reset(reset), .async_in(async_in), .sync_out(sync_out),
        .toggle_pulse(toggle_pulse), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
`ifdef PULSE_SYN_EDGE_CNT_EN
        , .edge_cnt(edge_cnt)
`endif
    );

    toggle_pulse_syn #(.WIDTH(1), .SYNC_STAGES(3), .RESET_VAL(1'b0)) dut3 (
        .clk(clk), .reset(reset), .async_in(async_in[0:0]), .sync_out(s3_sync),
        .toggle_pulse(s3_tog), .rise_pulse(s3_rise), .fall_pulse(s3_fall)
`ifdef PULSE_SYN_EDGE_CNT_EN
        , .edge_cnt(edge_cnt3)
`endif
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-computed directed vectors: reset, release, pulses, multi-bit, depth-3 level
    int         t_rst [21] = '{1,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0};
    logic [3:0] t_in  [21] = '{4'h1,4'h1,4'h1,4'h1,4'h1, 4'h0,4'h0,4'h1,4'h1,4'h1,
                               4'h1,4'h1,4'h0,4'h0,4'h0, 4'hA,4'hA,4'hA,4'h5,4'h5, 4'h5};
    logic [3:0] t_syn [21] = '{4'h0,4'h0,4'h0,4'h1,4'h1, 4'h1,4'h0,4'h0,4'h1,4'h1,
                               4'h1,4'h1,4'h1,4'h0,4'h0, 4'h0,4'hA,4'hA,4'hA,4'h5, 4'h5};
    logic [3:0] t_ris [21] = '{4'h0,4'h0,4'h0,4'h1,4'h0, 4'h0,4'h0,4'h0,4'h1,4'h0,
                               4'h0,4'h0,4'h0,4'h0,4'h0, 4'h0,4'hA,4'h0,4'h0,4'h5, 4'h0};
    logic [3:0] t_fal [21] = '{4'h0,4'h0,4'h0,4'h0,4'h0, 4'h0,4'h1,4'h0,4'h0,4'h0,
                               4'h0,4'h0,4'h0,4'h1,4'h0, 4'h0,4'h0,4'h0,4'h0,4'hA, 4'h0};
    logic       t_s3  [21] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,
                               1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1};
    logic [3:0] lat_vals [10] = '{4'h3,4'hC,4'hF,4'h0,4'h9,4'h6,4'h1,4'hE,4'h7,4'h8};

    // One row of stimulus; expectation from a two-deep input history model
    task automatic step(input logic r, input logic [3:0] v);
        exp_t e;
        @(negedge clk);
        reset = r;
        async_in = v;
        if (r) begin
            e = '0;
            p1 = 4'h0;
            p2 = 4'h0;
        end else begin
            e.sync = p1;
            e.rise = p1 & ~p2;
            e.fall = ~p1 & p2;
            e.tog  = p1 ^ p2;
            e.s3   = p2[0];
            p2 = p1;
            p1 = v;
        end
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
        #2;
        cmp("queue_drain", 16'(q.size()), 16'd0);
    endtask

    // Monitor: pops one expectation per edge and checks both instances
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            me = q.pop_front();
            cmp("sync_out", {12'h000, sync_out}, {12'h000, me.sync});
            cmp("rise_pulse", {12'h000, rise_pulse}, {12'h000, me.rise});
            cmp("fall_pulse", {12'h000, fall_pulse}, {12'h000, me.fall});
            cmp("toggle_pulse", {12'h000, toggle_pulse}, {12'h000, me.tog});
            cmp("depth3_sync", {15'h0000, s3_sync}, {15'h0000, me.s3});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            reset = (t_rst[k] != 0);
            async_in = t_in[k];
            e.sync = t_syn[k];
            e.rise = t_ris[k];
            e.fall = t_fal[k];
            e.tog  = t_ris[k] | t_fal[k];
            e.s3   = t_s3[k];
            q.push_back(e);
            if (reset) begin
                p1 = 4'h0;
                p2 = 4'h0;
            end else begin
                p2 = p1;
                p1 = t_in[k];
            end
        end

        // Latency: each value held two cycles
        for (int i = 0; i < 10; i++) begin
            step(1'b0, lat_vals[i]);
            step(1'b0, lat_vals[i]);
        end
        drain();

        // Reset mid-operation with a new value in flight
        step(1'b0, 4'hF);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        cmp("midrst_sync", {12'h000, sync_out}, 16'h0000);
        cmp("midrst_toggle", {12'h000, toggle_pulse}, 16'h0000);
        cmp("midrst_depth3", {15'h0000, s3_sync}, 16'h0000);
        step(1'b1, 4'hF);
        for (int i = 0; i < 4; i++) step(1'b0, 4'hF);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        drain();

`ifdef PULSE_SYN_EDGE_CNT_EN
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        drain();
        cmp("cnt_reset", edge_cnt, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h1);
        drain();
        cmp("cnt_three", edge_cnt, 16'h0003);
        @(negedge clk);
        force dut.edge_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.edge_cnt;
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0);
        drain();
        cmp("cnt_wrap", edge_cnt, 16'h0000);
        step(1'b1, 4'h0);
        drain();
        cmp("cnt_reset2", edge_cnt, 16'h0000);
        step(1'b0, 4'h0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
